// File: rtl/ram_ref_engine_pkg.sv
// ----------------------------------------------------------------------------
// ram_ref_engine_pkg
// Shared definitions for the WarpSE RAM refresh responder:
//   - FSM state encoding (2-bit) for the CBR refresh sequencer
//   - counter widths (refresh phase counter, miss counter)
//   - default CBR timing in FCLK cycles
//   - small helpers for counter load values and saturating increment
// ----------------------------------------------------------------------------
package ram_ref_engine_pkg;

    localparam int REF_CNT_W  = 3;
    localparam int MISS_CNT_W = 4;

    localparam int TCSR_DEF = 1;
    localparam int TRAS_DEF = 4;
    localparam int TRP_DEF  = 2;

    typedef logic [1:0] ref_state_t;

    localparam ref_state_t ST_IDLE = 2'b00;
    localparam ref_state_t ST_CAS  = 2'b01;
    localparam ref_state_t ST_RAS  = 2'b10;
    localparam ref_state_t ST_PRE  = 2'b11;

    // Phase counter load value: a phase lasting N cycles counts N-1 down to 0.
    function automatic logic [REF_CNT_W-1:0] cnt_load(input int cycles);
        logic [31:0] v;
        v = 32'(cycles - 1);
        return v[REF_CNT_W-1:0];
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
        logic [MISS_CNT_W-1:0] r;
        if (v == {MISS_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(MISS_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_ref_engine_sync2.sv
// ----------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer for single-bit levels crossing into the
// destination clock domain. Both stages clear asynchronously.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low clear
//   d_i    : asynchronous input level
//   q_o    : synchronized level (two destination edges of latency)
// ----------------------------------------------------------------------------
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ram_ref_engine.sv
// ----------------------------------------------------------------------------
// ram_ref_engine
// Refresh responder for the WarpSE RAM controller. Synchronizes the refresh
// request/urgency levels from the C16M domain and runs exactly one
// CAS-before-RAS refresh per request period: opportunistically while the FSB
// is idle, or forced at the next RAM access boundary once urgent.
// Ports:
//   FCLK      : FSB clock (sole clock)
//   nRES      : asynchronous active-low reset
//   RefReq    : refresh request level (C16M domain), rising edge = new period
//   RefUrgent : urgency level (C16M domain)
//   BACT      : FSB bus cycle active
//   RAMBusy   : RAM access in progress
//   RefHold   : blocks the RAM controller from starting a new access
//   RefBusy   : refresh sequence owns the RAM strobes
//   nRASref   : refresh RAS strobe, active-low
//   nCASref   : refresh CAS strobe, active-low (all lanes)
//   RefDone   : one-cycle pulse on the last precharge cycle
//   RefMiss   : sticky, set on the first missed refresh period
//   MissCnt   : saturating count of missed refresh periods
// ----------------------------------------------------------------------------
module ram_ref_engine
    import ram_ref_engine_pkg::*;
#(
    parameter int TCSR = TCSR_DEF,
    parameter int TRAS = TRAS_DEF,
    parameter int TRP  = TRP_DEF
) (
    input  logic                  FCLK,
    input  logic                  nRES,
    input  logic                  RefReq,
    input  logic                  RefUrgent,
    input  logic                  BACT,
    input  logic                  RAMBusy,
    output logic                  RefHold,
    output logic                  RefBusy,
    output logic                  nRASref,
    output logic                  nCASref,
    output logic                  RefDone,
    output logic                  RefMiss,
    output logic [MISS_CNT_W-1:0] MissCnt
);

    localparam logic [REF_CNT_W-1:0] TCSR_LD = cnt_load(TCSR);
    localparam logic [REF_CNT_W-1:0] TRAS_LD = cnt_load(TRAS);
    localparam logic [REF_CNT_W-1:0] TRP_LD  = cnt_load(TRP);
    localparam logic [REF_CNT_W-1:0] CNT_ONE = {{(REF_CNT_W-1){1'b0}}, 1'b1};

    logic req_s;
    logic urg_s;
    logic req_rise_s;
    logic start_s;
    logic overrun_s;

    logic                  req_dly_q;
    ref_state_t            state_q,   state_d;
    logic [REF_CNT_W-1:0]  cnt_q,     cnt_d;
    logic                  pending_q, pending_d;
    logic                  hold_q,    hold_d;
    logic                  busy_q,    busy_d;
    logic                  nras_q,    nras_d;
    logic                  ncas_q,    ncas_d;
    logic                  done_q,    done_d;
    logic                  miss_q,    miss_d;
    logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    sync2 u_sync_req (
        .clk_i  (FCLK),
        .rst_ni (nRES),
        .d_i    (RefReq),
        .q_o    (req_s)
    );

    sync2 u_sync_urg (
        .clk_i  (FCLK),
        .rst_ni (nRES),
        .d_i    (RefUrgent),
        .q_o    (urg_s)
    );

    assign req_rise_s = req_s & ~req_dly_q;

    // Once urgent, BACT no longer defers the refresh; RAMBusy always does so
    // an in-flight access is never corrupted.
    assign start_s   = (state_q == ST_IDLE) & pending_q & ~RAMBusy & (~BACT | urg_s);
    // A start in the same cycle consumes the old period, so the new rise is
    // simply the next owed refresh rather than a miss.
    assign overrun_s = req_rise_s & pending_q & ~start_s;

    // Sequencer next state and phase counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_CAS;
                    cnt_d   = TCSR_LD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_CAS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RAS;
                    cnt_d   = TRAS_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_RAS: begin
                if (cnt_q == '0) begin
                    state_d = ST_PRE;
                    cnt_d   = TRP_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending period bookkeeping and miss accounting.
    always_comb begin
        pending_d  = pending_q;
        miss_d     = miss_q;
        miss_cnt_d = miss_cnt_q;
        if (req_rise_s) begin
            pending_d = 1'b1;
        end else if (start_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (overrun_s) begin
            miss_d     = 1'b1;
            miss_cnt_d = sat_inc(miss_cnt_q);
        end else begin
            miss_d     = miss_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Outputs are decoded from the next state so the registered strobes
    // change on the same edge the sequencer enters a phase.
    always_comb begin
        ncas_d = ~((state_d == ST_CAS) | (state_d == ST_RAS));
        nras_d = ~(state_d == ST_RAS);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_PRE) & (cnt_d == '0);
        // Uses the current Pending, so the hold persists one cycle into CAS.
        hold_d = pending_q & urg_s;
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            req_dly_q  <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            nras_q     <= 1'b1;
            ncas_q     <= 1'b1;
            done_q     <= 1'b0;
            miss_q     <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            req_dly_q  <= req_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            nras_q     <= nras_d;
            ncas_q     <= ncas_d;
            done_q     <= done_d;
            miss_q     <= miss_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign RefHold = hold_q;
    assign RefBusy = busy_q;
    assign nRASref = nras_q;
    assign nCASref = ncas_q;
    assign RefDone = done_q;
    assign RefMiss = miss_q;
    assign MissCnt = miss_cnt_q;

endmodule

// File: tb/tb_ram_ref_engine.sv
// ----------------------------------------------------------------------------
// tb_ram_ref_engine
// Directed bench for ram_ref_engine at default timing (TCSR=1, TRAS=4, TRP=2).
// Inputs change 1 time unit after a rising FCLK edge; outputs are sampled at
// the same point.
// ----------------------------------------------------------------------------
module tb_ram_ref_engine;

    logic       FCLK;
    logic       nRES;
    logic       RefReq;
    logic       RefUrgent;
    logic       BACT;
    logic       RAMBusy;
    logic       RefHold;
    logic       RefBusy;
    logic       nRASref;
    logic       nCASref;
    logic       RefDone;
    logic       RefMiss;
    logic [3:0] MissCnt;

    int n_tests;
    int n_fail;

    ram_ref_engine dut (
        .FCLK      (FCLK),
        .nRES      (nRES),
        .RefReq    (RefReq),
        .RefUrgent (RefUrgent),
        .BACT      (BACT),
        .RAMBusy   (RAMBusy),
        .RefHold   (RefHold),
        .RefBusy   (RefBusy),
        .nRASref   (nRASref),
        .nCASref   (nCASref),
        .RefDone   (RefDone),
        .RefMiss   (RefMiss),
        .MissCnt   (MissCnt)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge FCLK);
            #1;
        end
    endtask

    task automatic pulse_req();
        RefReq = 1'b1;
        step(4);
        RefReq = 1'b0;
        step(4);
    endtask

    task automatic test_reset();
        n_tests++; if (nCASref !== 1'b1) begin n_fail++; $display("FAIL reset_ncas: got %b expected 1", nCASref); end
        n_tests++; if (nRASref !== 1'b1) begin n_fail++; $display("FAIL reset_nras: got %b expected 1", nRASref); end
        n_tests++; if (RefBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", RefBusy); end
        n_tests++; if (RefHold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0", RefHold); end
        n_tests++; if (RefDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", RefDone); end
        n_tests++; if (RefMiss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %b expected 0", RefMiss); end
        n_tests++; if (MissCnt !== 4'd0) begin n_fail++; $display("FAIL reset_misscnt: got %0d expected 0", MissCnt); end
    endtask

    // Idle bus: CAS at edge 4, RAS edges 5..8, PRE edges 9..10, done at 10.
    task automatic test_idle_refresh();
        logic e_ncas, e_nras, e_busy, e_done;
        BACT = 1'b0; RAMBusy = 1'b0; RefUrgent = 1'b0;
        RefReq = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            step(1);
            e_ncas = !(e >= 4 && e <= 8);
            e_nras = !(e >= 5 && e <= 8);
            e_busy = (e >= 4 && e <= 10);
            e_done = (e == 10);
            n_tests++; if (nCASref !== e_ncas) begin n_fail++; $display("FAIL idle_ncas edge %0d: got %b expected %b", e, nCASref, e_ncas); end
            n_tests++; if (nRASref !== e_nras) begin n_fail++; $display("FAIL idle_nras edge %0d: got %b expected %b", e, nRASref, e_nras); end
            n_tests++; if (RefBusy !== e_busy) begin n_fail++; $display("FAIL idle_busy edge %0d: got %b expected %b", e, RefBusy, e_busy); end
            n_tests++; if (RefDone !== e_done) begin n_fail++; $display("FAIL idle_done edge %0d: got %b expected %b", e, RefDone, e_done); end
        end
        n_tests++; if (MissCnt !== 4'd0) begin n_fail++; $display("FAIL idle_misscnt: got %0d expected 0", MissCnt); end
        RefReq = 1'b0;
        step(4);
    endtask

    task automatic test_urgent();
        int low_cnt;
        int cyc;
        BACT = 1'b1; RAMBusy = 1'b0; RefUrgent = 1'b0;
        RefReq = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (nCASref !== 1'b1) low_cnt++;
        end
        n_tests++; if (low_cnt != 0) begin n_fail++; $display("FAIL urg_no_start_bact: got %0d low cycles expected 0", low_cnt); end
        n_tests++; if (RefHold !== 1'b0) begin n_fail++; $display("FAIL urg_hold_pre: got %b expected 0", RefHold); end
        RefUrgent = 1'b1; RAMBusy = 1'b1;
        step(6);
        n_tests++; if (RefHold !== 1'b1) begin n_fail++; $display("FAIL urg_hold: got %b expected 1", RefHold); end
        n_tests++; if (nCASref !== 1'b1) begin n_fail++; $display("FAIL urg_no_start_busy: got %b expected 1", nCASref); end
        RAMBusy = 1'b0;
        step(1);
        n_tests++; if (nCASref !== 1'b0) begin n_fail++; $display("FAIL urg_cas: got %b expected 0", nCASref); end
        n_tests++; if (RefHold !== 1'b1) begin n_fail++; $display("FAIL urg_hold_cas: got %b expected 1", RefHold); end
        step(1);
        n_tests++; if (RefHold !== 1'b0) begin n_fail++; $display("FAIL urg_hold_drop: got %b expected 0", RefHold); end
        cyc = 0;
        while (RefBusy === 1'b1 && cyc < 40) begin step(1); cyc++; end
        n_tests++; if (RefBusy !== 1'b0) begin n_fail++; $display("FAIL urg_timeout: got busy %b expected 0", RefBusy); end
        RefUrgent = 1'b0; BACT = 1'b0; RefReq = 1'b0;
        step(4);
    endtask

    task automatic test_overrun();
        int dones;
        BACT = 1'b1; RAMBusy = 1'b1; RefUrgent = 1'b0;
        for (int r = 0; r < 3; r++) pulse_req();
        n_tests++; if (MissCnt !== 4'd2) begin n_fail++; $display("FAIL ovr_misscnt: got %0d expected 2", MissCnt); end
        n_tests++; if (RefMiss !== 1'b1) begin n_fail++; $display("FAIL ovr_refmiss: got %b expected 1", RefMiss); end
        n_tests++; if (RefBusy !== 1'b0) begin n_fail++; $display("FAIL ovr_no_start: got %b expected 0", RefBusy); end
        BACT = 1'b0; RAMBusy = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (RefDone === 1'b1) dones++;
        end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL ovr_one_refresh: got %0d refreshes expected 1", dones); end
        n_tests++; if (MissCnt !== 4'd2) begin n_fail++; $display("FAIL ovr_misscnt_hold: got %0d expected 2", MissCnt); end
    endtask

    task automatic test_same_cycle();
        int cyc;
        BACT = 1'b1; RAMBusy = 1'b0; RefUrgent = 1'b0;
        pulse_req();
        RefReq = 1'b1;
        step(2);
        // ReqRise is live in this cycle; dropping BACT makes start coincide.
        BACT = 1'b0;
        step(1);
        n_tests++; if (nCASref !== 1'b0) begin n_fail++; $display("FAIL same_cas: got %b expected 0", nCASref); end
        n_tests++; if (MissCnt !== 4'd2) begin n_fail++; $display("FAIL same_no_miss: got %0d expected 2", MissCnt); end
        step(6);
        n_tests++; if (RefDone !== 1'b1) begin n_fail++; $display("FAIL same_done: got %b expected 1", RefDone); end
        step(1);
        n_tests++; if (RefBusy !== 1'b0) begin n_fail++; $display("FAIL same_gap: got %b expected 0", RefBusy); end
        step(1);
        n_tests++; if (nCASref !== 1'b0) begin n_fail++; $display("FAIL same_second_cas: got %b expected 0", nCASref); end
        cyc = 0;
        while (RefBusy === 1'b1 && cyc < 40) begin step(1); cyc++; end
        n_tests++; if (RefBusy !== 1'b0) begin n_fail++; $display("FAIL same_timeout: got busy %b expected 0", RefBusy); end
        RefReq = 1'b0;
        step(4);
    endtask

    task automatic test_reset_mid();
        BACT = 1'b0; RAMBusy = 1'b0; RefUrgent = 1'b0;
        RefReq = 1'b1;
        step(5);
        n_tests++; if (nRASref !== 1'b0) begin n_fail++; $display("FAIL rst_pre_ras: got %b expected 0", nRASref); end
        #2;
        nRES = 1'b0;
        #1;
        n_tests++; if (nRASref !== 1'b1) begin n_fail++; $display("FAIL rst_async_nras: got %b expected 1", nRASref); end
        n_tests++; if (nCASref !== 1'b1) begin n_fail++; $display("FAIL rst_async_ncas: got %b expected 1", nCASref); end
        n_tests++; if (RefBusy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", RefBusy); end
        n_tests++; if (MissCnt !== 4'd0) begin n_fail++; $display("FAIL rst_misscnt: got %0d expected 0", MissCnt); end
        n_tests++; if (RefMiss !== 1'b0) begin n_fail++; $display("FAIL rst_refmiss: got %b expected 0", RefMiss); end
        RefReq = 1'b0;
        step(2);
        #3;
        nRES = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_tests++; if (RefBusy !== 1'b0) begin n_fail++; $display("FAIL rst_pending_cleared cycle %0d: got busy %b expected 0", i, RefBusy); end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] e_cnt;
        BACT = 1'b1; RAMBusy = 1'b1; RefUrgent = 1'b0;
        for (int r = 1; r <= 21; r++) begin
            pulse_req();
            e_cnt = (r - 1 > 15) ? 4'd15 : 4'(r - 1);
            n_tests++; if (MissCnt !== e_cnt) begin n_fail++; $display("FAIL sat_misscnt rise %0d: got %0d expected %0d", r, MissCnt, e_cnt); end
        end
        n_tests++; if (RefMiss !== 1'b1) begin n_fail++; $display("FAIL sat_refmiss: got %b expected 1", RefMiss); end
        BACT = 1'b0; RAMBusy = 1'b0;
        step(4);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nRES = 1'b0; RefReq = 1'b0; RefUrgent = 1'b0; BACT = 1'b0; RAMBusy = 1'b0;
        #23;
        nRES = 1'b1;
        step(2);
        test_reset();
        test_idle_refresh();
        test_urgent();
        test_overrun();
        test_same_cycle();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_ref_engine.md
# ram_ref_engine

Refresh responder for the WarpSE RAM controller. It consumes the `RefReq`/`RefUrgent` pair produced by the C16M-domain refresh timer, synchronizes both into the FCLK domain, and services each request period with exactly one CAS-before-RAS refresh cycle. Refresh is opportunistic while the FSB is idle and forced at the next RAM access boundary once urgent. It sits between the timer/counter block and the RAM strobe mux, and reports missed refresh periods for debug.

## Interface
- `TCSR`, default 1: FCLK cycles `nCAS` is low before `nRAS` falls; legal range 1..8.
- `TRAS`, default 4: FCLK cycles `nRAS` is low; legal range 1..8.
- `TRP`, default 2: FCLK cycles of precharge, both strobes high, before idle; legal range 1..8.

Ports:
- `FCLK` in 1: FSB clock; sole clock.
- `nRES` in 1: reset, asynchronous and active-low.
- `RefReq` in 1: refresh request level from the C16M domain; a rising edge opens a new period.
- `RefUrgent` in 1: urgency level from the C16M domain.
- `BACT` in 1: FSB bus cycle active (FCLK domain).
- `RAMBusy` in 1: RAM controller has a RAM access in progress (FCLK domain).
- `RefHold` out 1: blocks the RAM controller from starting a new access.
- `RefBusy` out 1: refresh sequence owns the RAM strobes.
- `nRASref` out 1: refresh RAS strobe, active-low.
- `nCASref` out 1: refresh CAS strobe, active-low; drives all CAS lanes.
- `RefDone` out 1: one-cycle pulse on the last PRE cycle.
- `RefMiss` out 1: sticky flag; set on first overrun.
- `MissCnt` out 4: saturating overrun count.

## Operation
- Synchronization: `RefReq` and `RefUrgent` each pass through two flops, giving `ReqS` and `UrgS`. `ReqRise` = `ReqS` & !`ReqS_d`.
- `Pending`: set on `ReqRise`; cleared on the IDLE->CAS transition. If `ReqRise` and the transition happen in the same cycle, `Pending` stays 1 and no miss is counted.
- Overrun: `ReqRise` while `Pending`=1 and no start that cycle. Effect: `MissCnt`+1, saturating at 15; `RefMiss` set. `Pending` stays 1, so only one refresh is owed.
- Start condition: `Pending` & !`RAMBusy` & (!`BACT` | `UrgS`).
- `RefHold` = `Pending` & `UrgS`, registered. It deasserts on the cycle after CAS is entered.
- FSM states are IDLE, CAS, RAS, PRE. A 3-bit down-counter `Cnt` loads parameter−1 on state entry.
  - IDLE: strobes high. Go to CAS on the start condition; `Cnt` ← `TCSR`−1.
  - CAS: `nCASref`=0, `nRASref`=1. At `Cnt`==0 go to RAS; `Cnt` ← `TRAS`−1.
  - RAS: `nCASref`=0, `nRASref`=0. At `Cnt`==0 go to PRE; `Cnt` ← `TRP`−1.
  - PRE: both strobes 1; `RefDone`=1 when `Cnt`==0; then go to IDLE.
- `RefBusy`=1 in CAS, RAS and PRE.
- `ReqRise` during CAS/RAS/PRE sets `Pending` for the next period and counts no miss.
- A new start may occur on the cycle after the last PRE cycle.
- Changes in `BACT`/`RAMBusy` after leaving IDLE do not abort a sequence; it always completes.

## Timing
- All outputs are registered. Reset values: `nRASref`=1, `nCASref`=1, `RefBusy`=0, `RefHold`=0, `RefDone`=0, `RefMiss`=0, `MissCnt`=0, FSM=IDLE, `Pending`=0, sync flops=0.
- `nRES` low mid-sequence drives the strobes high immediately (asynchronous) and discards `Pending`.
- `Pending` rises 3 FCLK edges after the first FCLK edge that samples `RefReq` high (2 sync stages + edge detect).
- The start condition true in cycle N gives `nCASref` low from edge N+1.
- Sequence length is `TCSR`+`TRAS`+`TRP` cycles; 7 at defaults.
- CBR ordering is guaranteed: CAS falls ≥1 cycle before RAS, both rise together at PRE entry, and RAS low time is exactly `TRAS`.

## Structure
- Shared package: FSM state encoding (2-bit), `REF_CNT_W`=3, `MISS_CNT_W`=4, default timing constants.
- Sub-module `sync2`: generic 2-flop synchronizer with async active-low clear, instantiated twice. Reused for other C16M→FCLK crossings.

## Test plan
- Idle bus (`BACT`=0, `RAMBusy`=0), `RefReq` rises -> `nCASref` low 4 FCLK later for 1 cycle, `nRASref` low 4 cycles, `RefDone` pulse after 7 cycles, `MissCnt`=0.
- `BACT`=1 continuously, `RefUrgent`=0 -> no refresh. Then `RefUrgent`=1 with `RAMBusy`=1 -> `RefHold`=1 and no start. `RAMBusy` falls -> CAS on the next edge, and `RefHold` drops one cycle later.
- Keep `BACT`=`RAMBusy`=1 with `UrgS`=0 across 3 `RefReq` rises -> `MissCnt`=2 and `RefMiss`=1. After release, exactly one refresh occurs.
- `ReqRise` on the same cycle as the IDLE->CAS start -> no miss, `Pending`=1, and a second refresh starts right after PRE.
- `nRES` asserted during RAS -> `nRASref`/`nCASref` high without an FCLK edge. After release: IDLE, `Pending`=0, all counters 0.
- Overrun 20 times -> `MissCnt` saturates at 15 with no wrap.
